// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell and a borrow
// register process one operand bit per clock; result is published with done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_cat;
  logic [CW-1:0]    count;
  logic             brw;
  logic             ai;
  logic             bi;
  logic             d;
  logic             brw_next;
  logic             last;

  // Full-subtractor cell on the current LSBs plus end-of-word detect
  always_comb begin
    ai       = a_sh[0];
    bi       = b_sh[0];
    d        = ai ^ bi ^ brw;
    brw_next = (~ai & bi) | (~(ai ^ bi) & brw);
    last     = (count == CW'(WIDTH - 1));
    r_cat    = {d, r_sh};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/result shifting and published outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh           <= '0;
      b_sh           <= '0;
      r_sh           <= '0;
      count          <= '0;
      brw            <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.busy <= (state_next == SHIFT);
      bus.done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw   <= 1'b0;
            count <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_cat[WIDTH-1:1];
          brw   <= brw_next;
          count <= count + CW'(1);
          // On the last bit ai/bi are the operand sign bits
          if (last) begin
            bus.diff       <= r_cat;
            bus.borrow_out <= brw_next;
            bus.overflow   <= (ai != bi) && (d != ai);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: 8-bit and 3-bit instances against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(3)) if3 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Returns {overflow, borrow, diff[7:0]} for a w-bit subtraction
  function automatic logic [9:0] ref_sub(input int w, input int a, input int b);
    int half, sa, sb, sd, d;
    logic bo, ov;
    half = 1 << (w - 1);
    d    = (a - b) & ((1 << w) - 1);
    bo   = (a < b);
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    sd   = sa - sb;
    ov   = (sd < -half) || (sd >= half);
    return {ov, bo, d[7:0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending result appears WIDTH edges after accept
  logic       m8_busy = 0, m8_done = 0, m8_bo = 0, m8_ov = 0;
  logic [7:0] m8_diff = 0;
  logic [9:0] m8_pend = 0;
  int         m8_rem = 0;
  logic       m3_busy = 0, m3_done = 0, m3_bo = 0, m3_ov = 0;
  logic [2:0] m3_diff = 0;
  logic [9:0] m3_pend = 0;
  int         m3_rem = 0;

  always @(posedge clk) begin
    if (rst) begin
      m8_busy <= 0; m8_done <= 0; m8_diff <= 0; m8_bo <= 0; m8_ov <= 0; m8_rem <= 0;
    end else if (m8_busy) begin
      m8_rem <= m8_rem - 1;
      if (m8_rem == 1) begin
        m8_busy <= 0; m8_done <= 1;
        m8_diff <= m8_pend[7:0]; m8_bo <= m8_pend[8]; m8_ov <= m8_pend[9];
      end
    end else if (m8_done) begin
      m8_done <= 0;
    end else if (if8.start) begin
      m8_pend <= ref_sub(8, int'(if8.a), int'(if8.b));
      m8_busy <= 1;
      m8_rem  <= 8;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m3_busy <= 0; m3_done <= 0; m3_diff <= 0; m3_bo <= 0; m3_ov <= 0; m3_rem <= 0;
    end else if (m3_busy) begin
      m3_rem <= m3_rem - 1;
      if (m3_rem == 1) begin
        m3_busy <= 0; m3_done <= 1;
        m3_diff <= m3_pend[2:0]; m3_bo <= m3_pend[8]; m3_ov <= m3_pend[9];
      end
    end else if (m3_done) begin
      m3_done <= 0;
    end else if (if3.start) begin
      m3_pend <= ref_sub(3, int'(if3.a), int'(if3.b));
      m3_busy <= 1;
      m3_rem  <= 3;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy8", int'(if8.busy), int'(m8_busy));
      check("done8", int'(if8.done), int'(m8_done));
      check("diff8", int'(if8.diff), int'(m8_diff));
      check("borrow8", int'(if8.borrow_out), int'(m8_bo));
      check("ovf8", int'(if8.overflow), int'(m8_ov));
      check("busy3", int'(if3.busy), int'(m3_busy));
      check("done3", int'(if3.done), int'(m3_done));
      check("diff3", int'(if3.diff), int'(m3_diff));
      check("borrow3", int'(if3.borrow_out), int'(m3_bo));
      check("ovf3", int'(if3.overflow), int'(m3_ov));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic ebo, input logic eov);
    int n;
    if8.start = 1'b1; if8.a = a; if8.b = b;
    step();
    if8.start = 1'b0;
    check({name, "_busy_after_accept"}, int'(if8.busy), 1);
    n = 1;
    while (!if8.done && n < 40) begin
      step();
      n++;
    end
    check({name, "_latency"}, n, 9);
    check({name, "_diff"}, int'(if8.diff), int'(ed));
    check({name, "_borrow"}, int'(if8.borrow_out), int'(ebo));
    check({name, "_ovf"}, int'(if8.overflow), int'(eov));
    step();
    check({name, "_done_one_cycle"}, int'(if8.done), 0);
  endtask

  task automatic count_done8(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (if8.done) dones++;
    end
  endtask

  initial begin
    int dones, n, pass3;
    logic [9:0] r;
    if8.start = 0; if8.a = 0; if8.b = 0;
    if3.start = 0; if3.a = 0; if3.b = 0;

    // Pin the model with hand-computed values
    check("model_5_3", int'(ref_sub(8, 5, 3)), int'({1'b0, 1'b0, 8'h02}));
    check("model_3_5", int'(ref_sub(8, 3, 5)), int'({1'b0, 1'b1, 8'hFE}));
    check("model_80_01", int'(ref_sub(8, 8'h80, 8'h01)), int'({1'b1, 1'b0, 8'h7F}));
    check("model_7f_ff", int'(ref_sub(8, 8'h7F, 8'hFF)), int'({1'b1, 1'b1, 8'h80}));
    check("model_w3_3_4", int'(ref_sub(3, 3, 4)), int'({1'b1, 1'b1, 8'h07}));

    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;
    check("reset_busy", int'(if8.busy), 0);
    check("reset_done", int'(if8.done), 0);
    check("reset_diff", int'(if8.diff), 0);

    run_op8("t5m3", 8'd5, 8'd3, 8'h02, 1'b0, 1'b0);
    run_op8("t3m5", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
    run_op8("t80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op8("t7fmff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op8("t0m0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op8("t0m1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op8("txmx", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

    // Start pulsed mid-operation with different operands is ignored
    if8.start = 1'b1; if8.a = 8'd10; if8.b = 8'd4;
    step();
    if8.start = 1'b0;
    repeat (3) step();
    if8.start = 1'b1; if8.a = 8'd1; if8.b = 8'd200;
    step();
    if8.start = 1'b0;
    count_done8(20, dones);
    check("ignore_start_dones", dones, 1);
    check("ignore_start_diff", int'(if8.diff), 6);

    // Reset four cycles into SHIFT aborts without a done
    if8.start = 1'b1; if8.a = 8'h55; if8.b = 8'h11;
    step();
    if8.start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", int'(if8.busy), 0);
    check("abort_diff", int'(if8.diff), 0);
    check("abort_done", int'(if8.done), 0);
    count_done8(12, dones);
    check("abort_no_done", dones, 0);
    run_op8("after_abort", 8'h55, 8'h11, 8'h44, 1'b0, 1'b0);

    // Exhaustive 3-bit sweep
    pass3 = 0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        if3.start = 1'b1; if3.a = a[2:0]; if3.b = b[2:0];
        step();
        if3.start = 1'b0;
        n = 1;
        while (!if3.done && n < 20) begin
          step();
          n++;
        end
        r = ref_sub(3, a, b);
        checks++;
        if (n == 4 && if3.diff == r[2:0] && if3.borrow_out == r[8] && if3.overflow == r[9]) begin
          pass3++;
        end else begin
          errors++;
          $display("FAIL w3_a%0d_b%0d actual=lat%0d/d%0d/b%0d/o%0d expected=lat4/d%0d/b%0d/o%0d",
                   a, b, n, if3.diff, if3.borrow_out, if3.overflow, r[2:0], r[8], r[9]);
        end
        step();
      end
    end
    check("w3_pass_count", pass3, 64);

    // Randomized traffic on both instances, including rare resets
    for (int i = 0; i < 4000; i++) begin
      if8.start = ($urandom_range(0, 3) != 0);
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      if3.start = ($urandom_range(0, 2) != 0);
      if3.a = 3'($urandom);
      if3.b = 3'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; if8.start = 1'b0; if3.start = 1'b0;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
